// File: rtl/mult_pipelined_pkg.sv
// Shared signed fixed-point helpers for the Q1.(BITS-1) datapath blocks (divider, multiplier).
// Functions work on a wide container so one package serves any BITS up to FX_W.
package mult_pipelined_pkg;
  localparam int FX_W = 64;
  typedef logic [FX_W-1:0] fx_t;

  function automatic fx_t fx_max_pos(input int bits);
    return (fx_t'(1) << (bits - 1)) - fx_t'(1);
  endfunction

  function automatic fx_t fx_min_neg(input int bits);
    return fx_t'(1) << (bits - 1);
  endfunction

  function automatic fx_t fx_neg(input fx_t x);
    return ~x + fx_t'(1);
  endfunction

  // x must be sign-extended into fx_t; the magnitude of -1 (2^(bits-1)) still fits in bits.
  function automatic fx_t fx_mag(input fx_t x, input logic sgn);
    return sgn ? fx_neg(x) : x;
  endfunction
endpackage

// File: rtl/mult_pipelined_stage.sv
// One shift-add stage: folds bit K-1 of |b| into the accumulator and forwards the operands.
module mult_pipelined_stage
  import mult_pipelined_pkg::*;
#(
  parameter int BITS = 8,
  parameter int K    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*BITS-1:0] acc_i,
  input  logic [BITS-1:0]   mag_a_i,
  input  logic [BITS-1:0]   mag_b_i,
  input  logic              neg_i,
  input  logic              vld_i,
  output logic [2*BITS-1:0] acc_o,
  output logic [BITS-1:0]   mag_a_o,
  output logic [BITS-1:0]   mag_b_o,
  output logic              neg_o,
  output logic              vld_o
);
  logic [2*BITS-1:0] acc_d;
  logic [2*BITS-1:0] acc_q;
  logic [BITS-1:0]   mag_a_q, mag_b_q;
  logic              neg_q, vld_q;

  always_comb begin
    acc_d = acc_i;
    if (mag_b_i[K-1]) acc_d = acc_i + ({{BITS{1'b0}}, mag_a_i} << (K - 1));
  end

  // Datapath always advances; only the valid bit needs reset.
  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    mag_a_q <= mag_a_i;
    mag_b_q <= mag_b_i;
    neg_q   <= neg_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= vld_i;
  end

  assign acc_o   = acc_q;
  assign mag_a_o = mag_a_q;
  assign mag_b_o = mag_b_q;
  assign neg_o   = neg_q;
  assign vld_o   = vld_q;
endmodule

// File: rtl/mult_pipelined.sv
// Signed Q1.(BITS-1) pipelined multiplier: sign strip, BITS shift-add stages, truncate/saturate.
// One op per cycle, latency BITS+2 cycles from start to data_valid.
module mult_pipelined
  import mult_pipelined_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] multiplicand,
  input  logic [BITS-1:0] multiplier,
  output logic            data_valid,
  output logic            overflow,
  output logic [BITS-1:0] product
);
  logic [BITS:0][2*BITS-1:0] acc_pipe;
  logic [BITS:0][BITS-1:0]   a_pipe, b_pipe;
  logic [BITS:0]             neg_pipe, vld_pipe;

  logic [BITS-1:0] mag_a_q, mag_b_q;
  logic            neg_q, vld0_q;

  always_ff @(posedge clk) begin
    mag_a_q <= BITS'(fx_mag(fx_t'($signed(multiplicand)), multiplicand[BITS-1]));
    mag_b_q <= BITS'(fx_mag(fx_t'($signed(multiplier)), multiplier[BITS-1]));
    neg_q   <= multiplicand[BITS-1] ^ multiplier[BITS-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld0_q <= 1'b0;
    else        vld0_q <= start;
  end

  assign acc_pipe[0] = '0;
  assign a_pipe[0]   = mag_a_q;
  assign b_pipe[0]   = mag_b_q;
  assign neg_pipe[0] = neg_q;
  assign vld_pipe[0] = vld0_q;

  for (genvar k = 1; k <= BITS; k++) begin : g_stage
    mult_pipelined_stage #(.BITS(BITS), .K(k)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .acc_i   (acc_pipe[k-1]),
      .mag_a_i (a_pipe[k-1]),
      .mag_b_i (b_pipe[k-1]),
      .neg_i   (neg_pipe[k-1]),
      .vld_i   (vld_pipe[k-1]),
      .acc_o   (acc_pipe[k]),
      .mag_a_o (a_pipe[k]),
      .mag_b_o (b_pipe[k]),
      .neg_o   (neg_pipe[k]),
      .vld_o   (vld_pipe[k])
    );
  end

  // Magnitude product is Q2.(2*BITS-2); dropping BITS-1 LSBs truncates toward zero.
  logic [BITS:0]   m;
  fx_t             m_ext;
  logic [BITS-1:0] product_d, product_q;
  logic            overflow_d, overflow_q, data_valid_q;

  always_comb begin
    m          = acc_pipe[BITS][2*BITS-1:BITS-1];
    m_ext      = fx_t'(m);
    product_d  = product_q;
    overflow_d = overflow_q;
    if (vld_pipe[BITS]) begin
      if (!neg_pipe[BITS] && m_ext >= fx_min_neg(BITS)) begin
        product_d  = BITS'(fx_max_pos(BITS));
        overflow_d = 1'b1;
      end else begin
        product_d  = neg_pipe[BITS] ? BITS'(fx_neg(m_ext)) : m[BITS-1:0];
        overflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q    <= '0;
      overflow_q   <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      product_q    <= product_d;
      overflow_q   <= overflow_d;
      data_valid_q <= vld_pipe[BITS];
    end
  end

  assign product    = product_q;
  assign overflow   = overflow_q;
  assign data_valid = data_valid_q;

  logic unused_ok;
  assign unused_ok = ^{a_pipe[BITS], b_pipe[BITS], acc_pipe[BITS][BITS-2:0]};
endmodule

// File: tb/tb_mult_pipelined.sv
// Directed bench for mult_pipelined at BITS=8: latency, saturation, truncation, streaming, reset.
module tb_mult_pipelined;
  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [BITS-1:0] multiplicand = '0;
  logic [BITS-1:0] multiplier = '0;
  logic            data_valid;
  logic            overflow;
  logic [BITS-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  mult_pipelined #(.BITS(BITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .data_valid   (data_valid),
    .overflow     (overflow),
    .product      (product)
  );

  always #5 clk = ~clk;

  // Independent reference: integer multiply, truncate magnitude, saturate +1 only.
  function automatic logic [8:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p, mag;
    p   = int'($signed(a)) * int'($signed(b));
    mag = ((p < 0) ? -p : p) >>> 7;
    if (p >= 0 && mag >= 128) return {1'b1, 8'h7F};
    if (p < 0) return {1'b0, 8'(-mag)};
    return {1'b0, 8'(mag)};
  endfunction

  // Issues one op and returns #1 after the edge where data_valid should first rise.
  task automatic issue_and_wait(input logic [7:0] a, input logic [7:0] b, output int early);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(posedge clk); #1;
    start = 1'b0;
    early = 0;
    repeat (BITS) begin
      @(posedge clk); #1;
      if (data_valid) early++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({data_valid, overflow, product} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_state: got dv=%0b ovf=%0b prod=%h, want 0/0/00", data_valid, overflow, product);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_dv: got %0b want 0", data_valid);
    end
  endtask

  task automatic run_table(input string tag, input logic [7:0] va[], input logic [7:0] vb[],
                           input logic [7:0] vp[], input logic vo[]);
    int early;
    for (int i = 0; i < va.size(); i++) begin
      issue_and_wait(va[i], vb[i], early);
      n_checks++;
      if (early != 0 || data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_latency[%0d]: early=%0d dv=%0b, want early=0 dv=1 at cycle 10", tag, i, early, data_valid);
      end
      n_checks++;
      if (product !== vp[i] || overflow !== vo[i]) begin
        n_fail++;
        $display("FAIL %s_result[%0d] %h*%h: got prod=%h ovf=%0b, want prod=%h ovf=%0b",
                 tag, i, va[i], vb[i], product, overflow, vp[i], vo[i]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (data_valid !== 1'b0 || product !== vp[i]) begin
        n_fail++;
        $display("FAIL %s_pulse_hold[%0d]: got dv=%0b prod=%h, want dv=0 prod=%h", tag, i, data_valid, product, vp[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] va[] = '{8'h40, 8'hC0, 8'h00};
    logic [7:0] vb[] = '{8'h40, 8'h40, 8'h80};
    logic [7:0] vp[] = '{8'h20, 8'hE0, 8'h00};
    logic       vo[] = '{1'b0, 1'b0, 1'b0};
    run_table("basic", va, vb, vp, vo);
  endtask

  task automatic test_saturation();
    logic [7:0] va[] = '{8'h80, 8'h80, 8'h80, 8'h7F};
    logic [7:0] vb[] = '{8'h80, 8'h7F, 8'h40, 8'h80};
    logic [7:0] vp[] = '{8'h7F, 8'h81, 8'hC0, 8'h81};
    logic       vo[] = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_table("sat", va, vb, vp, vo);
  endtask

  task automatic test_truncation();
    logic [7:0] va[] = '{8'h01, 8'hFF, 8'h7F, 8'hFF};
    logic [7:0] vb[] = '{8'h01, 8'h01, 8'h7F, 8'hFF};
    logic [7:0] vp[] = '{8'h00, 8'h00, 8'h7E, 8'h00};
    logic       vo[] = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_table("trunc", va, vb, vp, vo);
  endtask

  task automatic test_back_to_back();
    logic [7:0] sa[20], sb[20];
    logic [8:0] exp;
    logic [7:0] last_p;
    int idx;
    int bad_dv = 0, bad_val = 0;
    for (int i = 0; i < 20; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
    end
    sa[3] = 8'h80; sb[3] = 8'h80;
    sa[4] = 8'h80; sb[4] = 8'h7F;
    last_p = ref_mul(sa[19], sb[19]) & 9'h0FF;
    start = 1'b1; multiplicand = sa[0]; multiplier = sb[0];
    for (int j = 0; j < 32; j++) begin
      @(posedge clk); #1;
      idx = j - (BITS + 1);
      if (data_valid !== ((idx >= 0) && (idx < 20))) begin
        bad_dv++;
        $display("FAIL stream_dv[cycle %0d]: got %0b want %0b", j, data_valid, (idx >= 0) && (idx < 20));
      end else if (idx >= 0 && idx < 20) begin
        exp = ref_mul(sa[idx], sb[idx]);
        if ({overflow, product} !== exp) begin
          bad_val++;
          $display("FAIL stream_val[%0d] %h*%h: got ovf=%0b prod=%h, want ovf=%0b prod=%h",
                   idx, sa[idx], sb[idx], overflow, product, exp[8], exp[7:0]);
        end
      end
      start = (j + 1 < 20);
      if (j + 1 < 20) begin
        multiplicand = sa[j+1]; multiplier = sb[j+1];
      end
    end
    n_checks++;
    if (bad_dv != 0) n_fail++;
    n_checks++;
    if (bad_val != 0) n_fail++;
    n_checks++;
    if (data_valid !== 1'b0 || product !== last_p) begin
      n_fail++;
      $display("FAIL stream_idle_hold: got dv=%0b prod=%h, want dv=0 prod=%h", data_valid, product, last_p);
    end
  endtask

  task automatic test_reset_midstream();
    int early;
    int seen = 0;
    issue_and_wait(8'h40, 8'h40, early);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; multiplicand = 8'h80; multiplier = 8'h80;
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({data_valid, overflow, product} !== 10'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got dv=%0b ovf=%0b prod=%h, want 0/0/00", data_valid, overflow, product);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (data_valid) seen++;
    end
    n_checks++;
    if (seen != 0 || product !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_flushed: got dv pulses=%0d prod=%h, want 0 and 00", seen, product);
    end
    issue_and_wait(8'hC0, 8'hC0, early);
    n_checks++;
    if (early != 0 || data_valid !== 1'b1 || product !== 8'h20 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_new_op: got early=%0d dv=%0b prod=%h ovf=%0b, want 0/1/20/0",
               early, data_valid, product, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_truncation();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
